// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - four-source priority interrupt controller with mask, ack/return handshake and post-return holdoff
// Optional feature: define INT_EDGE_DETECT_EN for rising-edge source detection (default build is level-sensitive).
module interrupt_controller #(
    parameter logic [7:0] VEC_BASE       = 8'hF0,
    parameter logic [7:0] VEC_STRIDE     = 8'h04,
    parameter logic [2:0] HOLDOFF_CYCLES = 3'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq_src,
    input  logic       mask_wr,
    input  logic [3:0] mask_in,
    input  logic       int_ack,
    input  logic       int_ret,
    output logic       interrupt,
    output logic [7:0] vector,
    output logic [1:0] active_id,
    output logic       busy,
    output logic [3:0] pending,
    output logic [3:0] mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE,
        S_HOLDOFF
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic       interrupt_nx;
    logic       busy_nx;
    logic [7:0] vector_nx;
    logic [1:0] active_id_nx;
    logic [3:0] pending_nx;
    logic [3:0] mask_nx;
    logic [3:0] set;
    logic [3:0] clr;
    logic [3:0] eligible;
    logic [3:0] active_onehot;
    logic [1:0] winner;

`ifdef INT_EDGE_DETECT_EN
    logic [3:0] irq_src_q;

    // Previous-cycle copy of the sources so a held-high line pends only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_src_q <= 4'd0;
        end else begin
            irq_src_q <= irq_src;
        end
    end

    assign set = irq_src & ~irq_src_q;
`else
    assign set = irq_src;
`endif

    assign eligible      = pending & ~mask;
    assign active_onehot = 4'b0001 << active_id;

    // Fixed-priority pick: the lowest-index eligible source wins.
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 2'(i);
            end
        end
    end

    // Next-state and next-output logic; every output is a register so this only computes D inputs.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        interrupt_nx = interrupt;
        busy_nx      = busy;
        vector_nx    = vector;
        active_id_nx = active_id;
        clr          = 4'd0;
        mask_nx      = mask_wr ? mask_in : mask;
        unique case (state)
            S_IDLE: begin
                if (|eligible) begin
                    state_nx     = S_REQ;
                    interrupt_nx = 1'b1;
                    active_id_nx = winner;
                    vector_nx    = VEC_BASE + ({6'd0, winner} * VEC_STRIDE);
                end
            end
            S_REQ: begin
                // The ack beats a simultaneous masking write: once the core has jumped it must be serviced.
                if (int_ack) begin
                    clr          = active_onehot;
                    state_nx     = S_SERVICE;
                    interrupt_nx = 1'b0;
                    busy_nx      = 1'b1;
                end else if (mask_wr && |(mask_in & active_onehot)) begin
                    state_nx     = S_IDLE;
                    interrupt_nx = 1'b0;
                end
            end
            S_SERVICE: begin
                if (int_ret) begin
                    if (HOLDOFF_CYCLES == 3'd0) begin
                        state_nx = S_IDLE;
                        busy_nx  = 1'b0;
                    end else begin
                        state_nx = S_HOLDOFF;
                        cnt_nx   = HOLDOFF_CYCLES;
                    end
                end
            end
            S_HOLDOFF: begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nx = S_IDLE;
                    busy_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        pending_nx = (pending & ~clr) | set;
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            interrupt <= 1'b0;
            busy      <= 1'b0;
            vector    <= VEC_BASE;
            active_id <= 2'd0;
            pending   <= 4'd0;
            mask      <= 4'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            interrupt <= interrupt_nx;
            busy      <= busy_nx;
            vector    <= vector_nx;
            active_id <= active_id_nx;
            pending   <= pending_nx;
            mask      <= mask_nx;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;

    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       int_ret;
    logic       interrupt;
    logic [7:0] vector;
    logic [1:0] active_id;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] mask;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model: a request is outstanding, a service is in progress, or a holdoff countdown runs.
    bit         m_requesting = 1'b0;
    bit         m_in_service = 1'b0;
    int         m_hold_left  = 0;
    int         m_id         = 0;
    int         m_vec        = 240;
    logic [3:0] m_pend       = 4'd0;
    logic [3:0] m_mask       = 4'd0;
    logic [3:0] m_prev_irq   = 4'd0;
    logic [3:0] m_set;
    logic [3:0] m_clr;
    logic [3:0] m_elig;
    bit         m_found;

    interrupt_controller dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .int_ack   (int_ack),
        .int_ret   (int_ret),
        .interrupt (interrupt),
        .vector    (vector),
        .active_id (active_id),
        .busy      (busy),
        .pending   (pending),
        .mask      (mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_requesting = 1'b0;
            m_in_service = 1'b0;
            m_hold_left  = 0;
            m_id         = 0;
            m_vec        = 240;
            m_pend       = 4'd0;
            m_mask       = 4'd0;
            m_prev_irq   = 4'd0;
        end else begin
`ifdef INT_EDGE_DETECT_EN
            m_set = irq_src & ~m_prev_irq;
`else
            m_set = irq_src;
`endif
            m_clr = 4'd0;
            if (m_requesting) begin
                if (int_ack) begin
                    m_clr[m_id]  = 1'b1;
                    m_requesting = 1'b0;
                    m_in_service = 1'b1;
                end else if (mask_wr && mask_in[m_id]) begin
                    m_requesting = 1'b0;
                end
            end else if (m_in_service) begin
                if (int_ret) begin
                    m_in_service = 1'b0;
                    m_hold_left  = HOLD;
                end
            end else if (m_hold_left > 0) begin
                m_hold_left = m_hold_left - 1;
            end else begin
                m_elig  = m_pend & ~m_mask;
                m_found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (m_elig[i] && !m_found) begin
                        m_found = 1'b1;
                        m_id    = i;
                    end
                end
                if (m_found) begin
                    m_requesting = 1'b1;
                    m_vec        = (240 + 4 * m_id) % 256;
                end
            end
            m_pend = (m_pend & ~m_clr) | m_set;
            if (mask_wr) m_mask = mask_in;
            m_prev_irq = irq_src;
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            n_checks++;
            if (interrupt === m_requesting && busy === (m_in_service || m_hold_left > 0) &&
                vector === 8'(m_vec) && active_id === 2'(m_id) && pending === m_pend && mask === m_mask) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_cmp t=%0t actual int=%0b busy=%0b vec=%h id=%0d pend=%b mask=%b required int=%0b busy=%0b vec=%h id=%0d pend=%b mask=%b",
                         $time, interrupt, busy, vector, active_id, pending, mask,
                         m_requesting, (m_in_service || m_hold_left > 0), 8'(m_vec), m_id, m_pend, m_mask);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        irq_src = v;
        @(negedge clk);
        irq_src = 4'd0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        int_ret = 1'b1;
        @(negedge clk);
        int_ret = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_wr = 1'b1;
        mask_in = v;
        @(negedge clk);
        mask_wr = 1'b0;
    endtask

    task automatic serve();
        pulse_ack();
        pulse_ret();
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; irq_src = 4'd0; mask_wr = 1'b0; mask_in = 4'd0; int_ack = 1'b0; int_ret = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_interrupt", 32'(interrupt), 32'h0);
        check("rst_vector", 32'(vector), 32'hF0);
        check("rst_busy_pend_mask", {busy, pending, mask}, 32'h0);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // single source 2
        pulse_irq(4'b0100);
        check("s2_pending", 32'(pending), 32'b0100);
        check("s2_not_yet", 32'(interrupt), 32'h0);
        @(negedge clk);
        check("s2_req", {interrupt, 6'd0, active_id, vector}, {1'b1, 6'd0, 2'd2, 8'hF8});
        pulse_ack();
        check("s2_ack", {busy, pending}, {1'b1, 4'b0000});
        pulse_ret();
        repeat (HOLD) @(negedge clk);
        check("s2_drained", {busy, interrupt}, 32'h0);

        // two sources together, priority then the remaining one after holdoff
        pulse_irq(4'b1010);
        check("p_pending", 32'(pending), 32'b1010);
        @(negedge clk);
        check("p_first", {interrupt, active_id, vector}, {1'b1, 2'd1, 8'hF4});
        pulse_ack();
        pulse_ret();
        repeat (HOLD) @(negedge clk);
        check("p_holdoff_done", {busy, interrupt}, 32'h0);
        @(negedge clk);
        check("p_second", {interrupt, active_id, vector}, {1'b1, 2'd3, 8'hFC});
        serve();

        // no preemption by a later higher-priority source
        pulse_irq(4'b0100);
        @(negedge clk);
        pulse_irq(4'b0001);
        check("np_hold", {interrupt, active_id, pending}, {1'b1, 2'd2, 4'b0101});
        pulse_ack();
        check("np_ack", {busy, pending}, {1'b1, 4'b0001});
        pulse_ret();
        repeat (HOLD) @(negedge clk);
        @(negedge clk);
        check("np_next", {interrupt, active_id, vector}, {1'b1, 2'd0, 8'hF0});
        serve();

        // withdraw by masking, then unmask
        pulse_irq(4'b0100);
        @(negedge clk);
        write_mask(4'b0100);
        check("mk_withdraw", {interrupt, busy, pending, mask}, {1'b0, 1'b0, 4'b0100, 4'b0100});
        @(negedge clk);
        check("mk_stays_idle", 32'(interrupt), 32'h0);
        write_mask(4'b0000);
        @(negedge clk);
        check("mk_rerequest", {interrupt, active_id}, {1'b1, 2'd2});
        serve();

        // held-high source through the ack
        irq_src = 4'b0001;
        repeat (2) @(negedge clk);
        pulse_ack();
        irq_src = 4'b0000;
`ifdef INT_EDGE_DETECT_EN
        check("held_pend_once", {busy, pending}, {1'b1, 4'b0000});
        pulse_ret();
        repeat (HOLD + 1) @(negedge clk);
        check("held_no_rerequest", 32'(interrupt), 32'h0);
`else
        check("held_repend", {busy, pending}, {1'b1, 4'b0001});
        pulse_ret();
        repeat (HOLD + 1) @(negedge clk);
        check("held_rerequest", {interrupt, vector}, {1'b1, 8'hF0});
        serve();
`endif

        // asynchronous reset while in service
        pulse_irq(4'b0010);
        @(negedge clk);
        pulse_ack();
        write_mask(4'b1000);
        #3 reset = 1'b0;
        #1;
        check("async_rst", {interrupt, busy, active_id, pending, mask, vector}, {1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 8'hF0});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_ret();
        @(negedge clk);
        check("ret_ignored", {busy, interrupt}, 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            irq_src = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            mask_wr = ($urandom_range(0, 9) == 0);
            mask_in = 4'($urandom) & 4'($urandom);
            int_ack = ($urandom_range(0, 2) == 0);
            int_ret = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        reset = 1'b1; irq_src = 4'd0; mask_wr = 1'b0; int_ack = 1'b0; int_ret = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
